// File: rtl/alu_fpu_unit_if.sv
// Execute-stage operand/result bundle: integer and FP operand buses in, registered results out.
// The datapath side (master) drives operands; alu_fpu_unit (slave) drives the registered results.
interface alu_fpu_unit_if;
  logic [31:0] busA;
  logic [31:0] busB;
  logic [3:0]  ALUctrl;
  logic [31:0] fbusA;
  logic [31:0] fbusB;
  logic        FPUctrl;
  logic [31:0] ALUout;
  logic [31:0] FPUout;
  logic [31:0] busAout;
  logic [31:0] fbusAout;

  modport master (
    output busA, busB, ALUctrl, fbusA, fbusB, FPUctrl,
    input  ALUout, FPUout, busAout, fbusAout
  );

  modport slave (
    input  busA, busB, ALUctrl, fbusA, fbusB, FPUctrl,
    output ALUout, FPUout, busAout, fbusAout
  );
endinterface

// File: rtl/alu_fpu_unit.sv
// 32-bit integer ALU plus 32-bit multiplier with A-operand forwarding; every output registered once.
// Latency 1 cycle, one new operation accepted every cycle, no backpressure.
module alu_fpu_unit (
  input  logic         clk,
  input  logic         rst_n,
  alu_fpu_unit_if.slave io
);

  logic [31:0] alu_d, alu_q;
  logic [31:0] fpu_d, fpu_q;
  logic [31:0] busa_q, fbusa_q;
  logic [4:0]  shamt;
  logic        lt_s, lt_u, eq;

  assign shamt = io.busB[4:0];
  assign lt_s  = $signed(io.busA) < $signed(io.busB);
  assign lt_u  = io.busA < io.busB;
  assign eq    = io.busA == io.busB;

  always_comb begin
    alu_d = '0;
    case (io.ALUctrl)
      4'd0:  alu_d = io.busA + io.busB;
      4'd1:  alu_d = io.busA - io.busB;
      4'd2:  alu_d = io.busA & io.busB;
      4'd3:  alu_d = io.busA | io.busB;
      4'd4:  alu_d = io.busA ^ io.busB;
      4'd5:  alu_d = io.busA << shamt;
      4'd6:  alu_d = io.busA >> shamt;
      4'd7:  alu_d = $unsigned($signed(io.busA) >>> shamt);
      4'd8:  alu_d = {31'd0, lt_s};
      4'd9:  alu_d = {31'd0, lt_u};
      4'd10: alu_d = {31'd0, eq};
      4'd11: alu_d = {31'd0, !eq};
      4'd12: alu_d = {31'd0, !lt_s};
      4'd13: alu_d = {31'd0, !lt_s && !eq};
      4'd14: alu_d = {31'd0, lt_s || eq};
      4'd15: alu_d = {io.busB[15:0], 16'h0000};
      default: alu_d = '0;
    endcase
  end

  // The low product word is identical for signed and unsigned operands; both forms are kept explicit.
  always_comb begin
    fpu_d = '0;
    if (io.FPUctrl)
      fpu_d = 32'(io.fbusA * io.fbusB);
    else
      fpu_d = 32'($unsigned($signed(io.fbusA) * $signed(io.fbusB)));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_q   <= '0;
      fpu_q   <= '0;
      busa_q  <= '0;
      fbusa_q <= '0;
    end else begin
      alu_q   <= alu_d;
      fpu_q   <= fpu_d;
      busa_q  <= io.busA;
      fbusa_q <= io.fbusA;
    end
  end

  assign io.ALUout   = alu_q;
  assign io.FPUout   = fpu_q;
  assign io.busAout  = busa_q;
  assign io.fbusAout = fbusa_q;

endmodule

// File: tb/tb_alu_fpu_unit.sv
// Directed bench for alu_fpu_unit: expectations queued at drive time, popped one edge later.
module tb_alu_fpu_unit;

  logic clk;
  logic rst_n;
  alu_fpu_unit_if bus ();

  alu_fpu_unit dut (
    .clk   (clk),
    .rst_n (rst_n),
    .io    (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] alu;
    logic [31:0] fpu;
    logic [31:0] busa;
    logic [31:0] fbusa;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    assert (obs === exp_v) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
  endtask

  // Drive operands at the falling edge, queue the expectation, check after the next rising edge.
  task automatic step(input string tag,
                      input logic [31:0] a, input logic [31:0] b, input logic [3:0] ctl,
                      input logic [31:0] fa, input logic [31:0] fb, input logic fctl,
                      input logic [31:0] exp_alu, input logic [31:0] exp_fpu);
    exp_t e;
    @(negedge clk);
    bus.busA = a;  bus.busB = b;  bus.ALUctrl = ctl;
    bus.fbusA = fa; bus.fbusB = fb; bus.FPUctrl = fctl;
    e.alu = exp_alu; e.fpu = exp_fpu; e.busa = a; e.fbusa = fa;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      chk({tag, "_alu"},   bus.ALUout,   e.alu);
      chk({tag, "_fpu"},   bus.FPUout,   e.fpu);
      chk({tag, "_busa"},  bus.busAout,  e.busa);
      chk({tag, "_fbusa"}, bus.fbusAout, e.fbusa);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    bus.busA = 32'h1111_1111; bus.busB = 32'h2222_2222; bus.ALUctrl = 4'd0;
    bus.fbusA = 32'h3; bus.fbusB = 32'h4; bus.FPUctrl = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_alu",   bus.ALUout,   32'd0);
    chk("rst_fpu",   bus.FPUout,   32'd0);
    chk("rst_busa",  bus.busAout,  32'd0);
    chk("rst_fbusa", bus.fbusAout, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    step("add_first", 32'd2, 32'd4, 4'd0, 32'd7, 32'd6, 1'b0, 32'd6, 32'd42);
    step("add_wrap",  32'hFFFF_FFFF, 32'd1, 4'd0, 32'd0, 32'd0, 1'b0, 32'd0, 32'd0);
    step("sub_neg",   32'd3, 32'd5, 4'd1, 32'd0, 32'd0, 1'b0, 32'hFFFF_FFFE, 32'd0);
    step("and",       32'h0000_F0F0, 32'h0000_FF00, 4'd2, 32'd0, 32'd0, 1'b0, 32'h0000_F000, 32'd0);
    step("or",        32'h0000_F0F0, 32'h0000_FF00, 4'd3, 32'd0, 32'd0, 1'b0, 32'h0000_FFF0, 32'd0);
    step("xor",       32'h0000_F0F0, 32'h0000_FF00, 4'd4, 32'd0, 32'd0, 1'b0, 32'h0000_0FF0, 32'd0);
    step("sra4",      32'h8000_0010, 32'd4, 4'd7, 32'd0, 32'd0, 1'b0, 32'hF800_0001, 32'd0);
    step("srl4",      32'h8000_0010, 32'd4, 4'd6, 32'd0, 32'd0, 1'b0, 32'h0800_0001, 32'd0);
    step("sll_b21",   32'h8000_0010, 32'h21, 4'd5, 32'd0, 32'd0, 1'b0, 32'h0000_0020, 32'd0);
    step("sra_b20",   32'h8000_0010, 32'h20, 4'd7, 32'd0, 32'd0, 1'b0, 32'h8000_0010, 32'd0);
    step("slt",       32'hFFFF_FFFF, 32'd1, 4'd8,  32'd0, 32'd0, 1'b0, 32'd1, 32'd0);
    step("sltu",      32'hFFFF_FFFF, 32'd1, 4'd9,  32'd0, 32'd0, 1'b0, 32'd0, 32'd0);
    step("seq",       32'hFFFF_FFFF, 32'd1, 4'd10, 32'd0, 32'd0, 1'b0, 32'd0, 32'd0);
    step("seq_true",  32'd9, 32'd9, 4'd10, 32'd0, 32'd0, 1'b0, 32'd1, 32'd0);
    step("sne",       32'hFFFF_FFFF, 32'd1, 4'd11, 32'd0, 32'd0, 1'b0, 32'd1, 32'd0);
    step("sge",       32'hFFFF_FFFF, 32'd1, 4'd12, 32'd0, 32'd0, 1'b0, 32'd0, 32'd0);
    step("sgt",       32'hFFFF_FFFF, 32'd1, 4'd13, 32'd0, 32'd0, 1'b0, 32'd0, 32'd0);
    step("sle",       32'hFFFF_FFFF, 32'd1, 4'd14, 32'd0, 32'd0, 1'b0, 32'd1, 32'd0);
    step("sle_eq",    32'd5, 32'd5, 4'd14, 32'd0, 32'd0, 1'b0, 32'd1, 32'd0);
    step("lhi",       32'hDEAD_BEEF, 32'h0000_1234, 4'd15, 32'd0, 32'd0, 1'b0, 32'h1234_0000, 32'd0);

    step("mul_s",     32'd0, 32'd0, 4'd0, 32'hFFFF_FFFE, 32'd3, 1'b0, 32'd0, 32'hFFFF_FFFA);
    step("mul_u",     32'd0, 32'd0, 4'd0, 32'hFFFF_FFFE, 32'd3, 1'b1, 32'd0, 32'hFFFF_FFFA);
    step("mul_trunc", 32'd0, 32'd0, 4'd0, 32'h0001_0000, 32'h0001_0000, 1'b0, 32'd0, 32'd0);
    step("mul_negneg",32'd0, 32'd0, 4'd0, 32'hFFFF_FFFD, 32'hFFFF_FFFB, 1'b0, 32'd0, 32'd15);

    for (int i = 1; i <= 6; i++)
      step("pipe", 32'(i), 32'(i), 4'd0, 32'(i + 100), 32'd2, 1'b0, 32'(2 * i), 32'(2 * (i + 100)));

    // Outputs are nonzero here; reset asserted mid-cycle must clear them without a clock edge.
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_alu",   bus.ALUout,   32'd0);
    chk("arst_fpu",   bus.FPUout,   32'd0);
    chk("arst_busa",  bus.busAout,  32'd0);
    chk("arst_fbusa", bus.fbusAout, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step("post_rst",  32'd10, 32'd3, 4'd1, 32'd5, 32'd5, 1'b1, 32'd7, 32'd25);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
